// File: rtl/gate_resp_checker.sv
// gate_resp_checker
//   Receiving end of a two-input gate stimulus stream. For each accepted
//   stimulus {a,b} it computes the expected output of the selected gate
//   function. It delays that expectation by the device latency LAT, compares
//   it against the device output y, and counts mismatches. At the end of the
//   run it gives a pass/fail verdict.
//
// Parameters
//   NVEC  : vectors per run (1 .. 2^CNT_W-1)
//   LAT   : device latency in cycles from stimulus to y (0 .. 7)
//   CNT_W : width of the vector and error counters
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst            : synchronous active-high reset
//   start          : begin a run (taken in IDLE or DONE only)
//   func[2:0]      : gate function, latched at start
//                    0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 expect 0
//   vld, a, b      : stimulus valid and stimulus bits
//   y              : device output, compared LAT cycles after its vld
//   busy           : high while running
//   done           : high once all NVEC compares have completed
//   pass           : high in DONE when no mismatch was seen
//   err_cnt        : saturating mismatch count
//   fail_seen      : sticky first-mismatch flag
//   first_fail_idx : 0-based index of the first mismatching vector
//   first_fail_ab  : {a,b} of the first mismatching vector
//   sig[15:0]      : MISR signature (only when GATE_CHK_MISR_EN is defined)
//
// Optional feature macro: GATE_CHK_MISR_EN adds a 16-bit Galois MISR over
// {y,a,b} of every compare (x^16+x^14+x^13+x^11+1, seed 16'hFFFF).

module gate_resp_checker #(
  parameter int unsigned NVEC  = 4,
  parameter int unsigned LAT   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [1:0]       first_fail_ab
`ifdef GATE_CHK_MISR_EN
  ,
  output logic [15:0]      sig
`endif
);

  localparam logic [CNT_W-1:0] NVEC_C = CNT_W'(NVEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // One delay-line slot: valid, expected value, and the stimulus that made it.
  typedef struct packed {
    logic v;
    logic e;
    logic a;
    logic b;
  } ent_t;

  function automatic logic gate_fn(input logic [2:0] f, input logic ia, input logic ib);
    logic r;
    unique case (f)
      3'd0:    r = ia & ib;
      3'd1:    r = ia | ib;
      3'd2:    r = ~(ia & ib);
      3'd3:    r = ~(ia | ib);
      3'd4:    r = ia ^ ib;
      3'd5:    r = ~(ia ^ ib);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

`ifdef GATE_CHK_MISR_EN
  // Left-shifting Galois MISR; the taps 16'h6801 are x^14, x^13, x^11 and x^0.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic iy,
                                            input logic ia, input logic ib);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) begin
      n = n ^ 16'h6801;
    end
    n[2:0] = n[2:0] ^ {iy, ia, ib};
    return n;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [2:0]       func_q, func_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_seen_q, fail_seen_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [1:0]       ffab_q, ffab_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
`ifdef GATE_CHK_MISR_EN
  logic [15:0]      misr_q, misr_d;
`endif

  logic start_run;
  logic accept;
  ent_t push;
  ent_t tail;
  logic cmp_valid;
  logic mismatch;

  assign start_run = start && (state_q != S_RUN);
  assign accept    = (state_q == S_RUN) && vld && (acc_cnt_q < NVEC_C);

  always_comb begin
    push   = '0;
    push.v = accept;
    push.e = gate_fn(func_q, a, b);
    push.a = a;
    push.b = b;
  end

  // Expectation delay line. It shifts every cycle regardless of vld, so gaps
  // in the stimulus stay aligned with the device latency. With LAT = 0 the
  // accepted vector is compared against y in the same cycle.
  if (LAT == 0) begin : g_nodly
    assign tail = push;
  end else begin : g_dly
    ent_t dl_q [LAT];
    ent_t dl_d [LAT];

    always_comb begin
      dl_d[0] = push;
      for (int unsigned i = 1; i < LAT; i++) begin
        dl_d[i] = dl_q[i-1];
      end
      if (start_run) begin
        for (int unsigned i = 0; i < LAT; i++) begin
          dl_d[i] = '0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < LAT; i++) begin
          dl_q[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < LAT; i++) begin
          dl_q[i] <= dl_d[i];
        end
      end
    end

    assign tail = dl_q[LAT-1];
  end

  assign cmp_valid = tail.v && (state_q == S_RUN);
  assign mismatch  = cmp_valid && (tail.e != y);

  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    acc_cnt_d   = acc_cnt_q;
    cmp_cnt_d   = cmp_cnt_q;
    err_cnt_d   = err_cnt_q;
    fail_seen_d = fail_seen_q;
    ffi_d       = ffi_q;
    ffab_d      = ffab_q;
`ifdef GATE_CHK_MISR_EN
    misr_d      = misr_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          func_d      = func;
          acc_cnt_d   = '0;
          cmp_cnt_d   = '0;
          err_cnt_d   = '0;
          fail_seen_d = 1'b0;
          ffi_d       = '0;
          ffab_d      = '0;
`ifdef GATE_CHK_MISR_EN
          misr_d      = 16'hFFFF;
`endif
        end
      end
      S_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
        end
        if (cmp_valid) begin
          cmp_cnt_d = cmp_cnt_q + 1'b1;
`ifdef GATE_CHK_MISR_EN
          misr_d    = misr_step(misr_q, y, tail.a, tail.b);
`endif
          if (mismatch) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              ffi_d       = cmp_cnt_q;
              ffab_d      = {tail.a, tail.b};
            end
          end
          if (cmp_cnt_d == NVEC_C) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state flop.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      func_q      <= '0;
      acc_cnt_q   <= '0;
      cmp_cnt_q   <= '0;
      err_cnt_q   <= '0;
      fail_seen_q <= 1'b0;
      ffi_q       <= '0;
      ffab_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
`ifdef GATE_CHK_MISR_EN
      misr_q      <= 16'hFFFF;
`endif
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      acc_cnt_q   <= acc_cnt_d;
      cmp_cnt_q   <= cmp_cnt_d;
      err_cnt_q   <= err_cnt_d;
      fail_seen_q <= fail_seen_d;
      ffi_q       <= ffi_d;
      ffab_q      <= ffab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
`ifdef GATE_CHK_MISR_EN
      misr_q      <= misr_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_ab  = ffab_q;
`ifdef GATE_CHK_MISR_EN
  assign sig            = misr_q;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker. Two instances share the stimulus: one with
// LAT=0, where y is presented with the vector, and one with LAT=2, where y is
// delayed two cycles by a bench-side pipe. Expected results are derived from
// the list of vectors the bench itself knows were accepted.

module tb_gate_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, vld, a, b, yval;
  logic [2:0] func;
  logic [1:0] yd;
  logic       y0, y2;

  logic       busy0, done0, pass0, fs0;
  logic [7:0] err0, ffi0;
  logic [1:0] ffab0;
  logic       busy2, done2, pass2, fs2;
  logic [7:0] err2, ffi2;
  logic [1:0] ffab2;
`ifdef GATE_CHK_MISR_EN
  logic [15:0] sig0, sig2;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Device-side latency model for the LAT=2 instance.
  always @(posedge clk) yd <= {yd[0], yval};
  assign y0 = yval;
  assign y2 = yd[1];

  gate_resp_checker #(.NVEC(4), .LAT(0), .CNT_W(8)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .func(func), .vld(vld), .a(a), .b(b), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_seen(fs0),
    .first_fail_idx(ffi0), .first_fail_ab(ffab0)
`ifdef GATE_CHK_MISR_EN
    , .sig(sig0)
`endif
  );

  gate_resp_checker #(.NVEC(4), .LAT(2), .CNT_W(8)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .func(func), .vld(vld), .a(a), .b(b), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_seen(fs2),
    .first_fail_idx(ffi2), .first_fail_ab(ffab2)
`ifdef GATE_CHK_MISR_EN
    , .sig(sig2)
`endif
  );

  typedef struct {
    logic [2:0] f;
    logic [7:0] ab;   // vector 0 in [7:6]
    logic [3:0] y;    // vector 0 in [3]
    int         err;
    int         fidx;
    int         fab;
  } vec_t;

  vec_t tbl [11];

  function automatic logic ref_gate(input logic [2:0] f, input logic ia, input logic ib);
    int n;
    n = int'(ia) + int'(ib);
    case (f)
      3'd0: return n == 2;
      3'd1: return n >= 1;
      3'd2: return n != 2;
      3'd3: return n == 0;
      3'd4: return n == 1;
      3'd5: return n != 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic iy,
                                           input logic ia, input logic ib);
    logic [16:0] w;
    w = {s, 1'b0};
    if (w[16]) w = w ^ 17'h16801;   // reduce by x^16+x^14+x^13+x^11+1
    return w[15:0] ^ {13'd0, iy, ia, ib};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [2:0] f);
    start = 1'b1;
    func  = f;
    vld   = 1'b1;                   // same-cycle vld must be ignored
    a     = 1'($urandom_range(0, 1));
    b     = 1'($urandom_range(0, 1));
    yval  = ~ref_gate(f, a, b);
    tick();
    start = 1'b0;
    vld   = 1'b0;
  endtask

  task automatic send(input logic ia, input logic ib, input logic iy, input logic st);
    vld   = 1'b1;
    a     = ia;
    b     = ib;
    yval  = iy;
    start = st;
    tick();
    vld   = 1'b0;
    start = 1'b0;
    yval  = 1'($urandom_range(0, 1));
  endtask

  task automatic gap();
    vld  = 1'b0;
    a    = 1'($urandom_range(0, 1));
    b    = 1'($urandom_range(0, 1));
    yval = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !(done0 && done2); i++) tick();
    chk("done_timeout", int'(done0 && done2), 1);
  endtask

  task automatic check_result(input string tag, input int e_err, input int e_fidx,
                              input int e_fab, input logic [15:0] e_sig);
    chk({tag, ".done0"}, done0, 1);
    chk({tag, ".pass0"}, pass0, int'(e_err == 0));
    chk({tag, ".busy0"}, busy0, 0);
    chk({tag, ".err0"},  err0, e_err);
    chk({tag, ".fs0"},   fs0, int'(e_err != 0));
    chk({tag, ".ffi0"},  ffi0, e_fidx);
    chk({tag, ".ffab0"}, ffab0, e_fab);
    chk({tag, ".done2"}, done2, 1);
    chk({tag, ".pass2"}, pass2, int'(e_err == 0));
    chk({tag, ".err2"},  err2, e_err);
    chk({tag, ".fs2"},   fs2, int'(e_err != 0));
    chk({tag, ".ffi2"},  ffi2, e_fidx);
    chk({tag, ".ffab2"}, ffab2, e_fab);
`ifdef GATE_CHK_MISR_EN
    chk({tag, ".sig0"},  sig0, e_sig);
    chk({tag, ".sig2"},  sig2, e_sig);
`else
    if (e_sig == 16'h0) $display("note: %s zero signature", tag);
`endif
  endtask

  task automatic run_tbl(input vec_t t, input string tag);
    logic [15:0] m;
    logic ia, ib, iy;
    m = 16'hFFFF;
    start_run(t.f);
    for (int k = 0; k < 4; k++) begin
      ia = t.ab[7-2*k];
      ib = t.ab[6-2*k];
      iy = t.y[3-k];
      send(ia, ib, iy, 1'b0);
      m = ref_misr(m, iy, ia, ib);
    end
    wait_done();
    check_result(tag, t.err, t.fidx, t.fab, m);
  endtask

  task automatic run_random(input int r);
    logic [2:0] f;
    logic ia, ib, fl;
    logic [15:0] m;
    int e_err, e_fidx, e_fab;
    string tag;
    tag = $sformatf("rnd%0d", r);
    f = 3'($urandom_range(0, 7));
    m = 16'hFFFF;
    e_err = 0; e_fidx = 0; e_fab = 0;
    start_run(f);
    for (int k = 0; k < 4; k++) begin
      while ($urandom_range(0, 3) == 0) gap();
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 4) == 0);
      if (fl) begin
        if (e_err == 0) begin
          e_fidx = k;
          e_fab  = {30'd0, ia, ib};
        end
        e_err++;
      end
      send(ia, ib, ref_gate(f, ia, ib) ^ fl, ($urandom_range(0, 9) == 0));
      m = ref_misr(m, ref_gate(f, ia, ib) ^ fl, ia, ib);
    end
    chk({tag, ".done0_edge"}, done0, 1);
    chk({tag, ".done2_early"}, done2, 0);
    for (int x = $urandom_range(0, 2); x > 0; x--)
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    wait_done();
    check_result(tag, e_err, e_fidx, e_fab, m);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 8'b00_01_10_11, 4'b0001, 0, 0, 0};
    tbl[1]  = '{3'd0, 8'b00_01_10_11, 4'b0000, 1, 3, 3};
    tbl[2]  = '{3'd1, 8'b00_01_10_11, 4'b0111, 0, 0, 0};
    tbl[3]  = '{3'd2, 8'b00_01_10_11, 4'b1110, 0, 0, 0};
    tbl[4]  = '{3'd3, 8'b00_01_10_11, 4'b1000, 0, 0, 0};
    tbl[5]  = '{3'd4, 8'b00_01_10_11, 4'b0110, 0, 0, 0};
    tbl[6]  = '{3'd5, 8'b00_01_10_11, 4'b1001, 0, 0, 0};
    tbl[7]  = '{3'd6, 8'b00_01_10_11, 4'b0000, 0, 0, 0};
    tbl[8]  = '{3'd7, 8'b00_01_10_11, 4'b1111, 4, 0, 0};
    tbl[9]  = '{3'd4, 8'b00_01_10_11, 4'b0000, 2, 1, 1};
    tbl[10] = '{3'd1, 8'b00_01_10_11, 4'b1111, 1, 0, 0};

    rst = 1'b1; start = 1'b0; vld = 1'b0; a = 1'b0; b = 1'b0; yval = 1'b0; func = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.busy0", busy0, 0);
    chk("rst.done0", done0, 0);
    chk("rst.pass0", pass0, 0);
    chk("rst.err0", err0, 0);
    chk("rst.fs0", fs0, 0);
    chk("rst.ffi0", ffi0, 0);
    chk("rst.ffab0", ffab0, 0);
    chk("rst.busy2", busy2, 0);
    chk("rst.done2", done2, 0);
    chk("rst.pass2", pass2, 0);
`ifdef GATE_CHK_MISR_EN
    chk("rst.sig0", sig0, 16'hFFFF);
`endif

    // vld in IDLE counts nowhere
    send(1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle_vld.err0", err0, 0);
    chk("idle_vld.busy0", busy0, 0);

    for (int i = 0; i < 11; i++) run_tbl(tbl[i], $sformatf("tbl%0d", i));

    // XOR with a vld gap; LAT=2 done follows the last accept by two compares.
    start_run(3'd4);
    chk("gap.busy0", busy0, 1);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b1, 1'b0);
    gap();
    send(1'b1, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap.done0", done0, 1);
    chk("gap.pass0", pass0, 1);
    chk("gap.done2_e0", done2, 0);
    chk("gap.busy2_e0", busy2, 1);
    gap();
    chk("gap.done2_e1", done2, 0);
    gap();
    chk("gap.done2_e2", done2, 1);
    chk("gap.pass2", pass2, 1);
    chk("gap.err2", err2, 0);

    // NAND with six vld pulses and a start during RUN; extras carry wrong y.
    start_run(3'd2);
    send(1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1, 1'b1);
    send(1'b1, 1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    wait_done();
    check_result("six", 0, 0, 0,
                 ref_misr(ref_misr(ref_misr(ref_misr(16'hFFFF, 1'b1, 1'b0, 1'b0),
                 1'b0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0));

    // Reset mid-run with a mismatch still in the LAT=2 delay line.
    start_run(3'd0);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid.err0", err0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.busy0", busy0, 0);
    chk("mid.err0_clr", err0, 0);
    chk("mid.fs0", fs0, 0);
    chk("mid.busy2", busy2, 0);
    chk("mid.err2", err2, 0);
    chk("mid.fs2", fs2, 0);
    gap();
    gap();
    chk("mid.err2_late", err2, 0);
    chk("mid.done2", done2, 0);
    run_tbl(tbl[0], "restart");

    for (int r = 0; r < 25; r++) run_random(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
